bus_slot_sequencer: RTL and testbench
=====================================

# bus_slot_sequencer

Generates the 2-bit slot index `cnt` and enable `en` that drive the one-hot select decoder of the tri-state shared bus. Four sources take turns on the bus in round-robin order, advanced by a programmable prescaler tick or by a single-step input. Sources without a pending request are skipped. Every change of slot is break-before-make: `en` drops for one cycle before `cnt` changes, so no two tri-state drivers are ever enabled together.

## Interface
Parameters:
- `TICK_DIV`, default 100_000_000: clocks per slot dwell in run mode. Must be ≥2. The prescaler is `$clog2(TICK_DIV)` bits wide.

Ports:
- `clk` input 1: single system clock; everything is on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `run` input 1: level; enables automatic advance on the prescaler tick.
- `step` input 1: synchronous level. Each rising edge, detected internally, requests one advance.
- `req` input 4: per-source request, where bit i corresponds to slot i.
- `cnt` output 2: current slot index, fed to the decoder.
- `en` output 1: decoder enable; 1 only in state GRANT.
- `adv` output 1: one-cycle pulse in the cycle the block enters GAP.

## Operation
- States:
  - IDLE: `en`=0; `cnt` holds.
  - GAP: `en`=0 for exactly 1 cycle; `cnt` takes the new slot.
  - GRANT: `en`=1.
- Next-slot search:
  - Scan `cnt+1`, `cnt+2`, `cnt+3`, then `cnt` (mod 4).
  - The first slot with its `req` bit set wins.
- Advance event, evaluated only in GRANT. Any of:
  - `run`=1 and the prescaler is at `TICK_DIV-1`;
  - a rising edge on `step`;
  - `req[cnt]`=0.
  - Several of these in the same cycle produce a single advance.
- Transitions:
  - IDLE → GAP when `req`≠0.
  - GRANT → IDLE on an advance with `req`=0.
  - GRANT → GAP on an advance where the search result differs from `cnt`.
  - GRANT → GRANT on an advance where the search result equals `cnt`: no gap, `adv` stays 0, prescaler restarts.
  - GAP → GRANT unconditionally.
- Prescaler:
  - Counts only in GRANT with `run`=1.
  - Clears to 0 on entry to GRANT, on any advance, and when `run`=0 (so each dwell is a full period).
- Step edge detector:
  - Registers `step`.
  - The edge is recognised only in GRANT and is dropped in other states; it is never queued.
- `req` changes during GAP do not alter the slot already loaded.

## Timing
- Reset values: state IDLE, `cnt`=2'b11 (so the first grant goes to slot 0), `en`=0, `adv`=0, prescaler 0, step register 0.
- All outputs are registered or decoded from the state register, so they are glitch-free.
- IDLE with `req` rising in cycle N:
  - N+1: GAP, `cnt` = new slot, `adv`=1.
  - N+2: GRANT, `en`=1.
- Run-mode dwell:
  - `en`=1 for exactly `TICK_DIV` cycles.
  - Then 1 GAP cycle, giving a period of `TICK_DIV+1` per slot.
- Step edge in cycle N (registered edge is seen at N+1):
  - GAP at N+2.
- Reset asserted mid-operation: `en` falls asynchronously; the block restarts from IDLE with `cnt`=3.

## Structure
- Package `bus_seq_pkg` holds:
  - state enum `seq_state_t` (IDLE, GAP, GRANT);
  - `SLOT_W`=2, `N_SLOTS`=4;
  - function `rr_next(cnt, req)` returning the next slot and a found flag.
- One sub-module, `slot_prescaler`: counter with clear and enable, and a terminal-count output.
- The top level contains the FSM, the step edge detector, and the `cnt`/`adv` registers.

## Test plan
All scenarios use `TICK_DIV`=4.
- Reset release with `req`=4'b1111, `run`=1:
  - `cnt` sequence is 0,1,2,3,0.
  - Each slot has `en`=1 for 4 cycles, then 1 cycle of `en`=0.
  - `adv` pulses once per slot change.
- `req`=4'b0101, `run`=1: `cnt` alternates 0,2,0; slots 1 and 3 never granted.
- `run`=0, `req`=4'b1111, three isolated `step` pulses, the first arriving in GRANT with `cnt`=0: GAP 2 cycles after each edge; `cnt` 0→1→2→3.
- In GRANT at slot 1, `req` drops from 4'b0010 to 4'b0000: GRANT→IDLE next cycle, `en`=0, `cnt` stays 1. Then setting `req`=4'b0001 gives GAP with `cnt`=0, then GRANT.
- `req`=4'b1000 only, `run`=1: `cnt` stays 3 and `en` stays 1 continuously; no GAP, no `adv`.
- Break-before-make check across all of the above: assert every `cnt` change coincides with `en`=0; `rst_n` asserted during GRANT forces `en`=0 immediately.

Source files
------------

// File: rtl/bus_seq_pkg.sv
// Shared types, sizes and the round-robin search used by the bus slot sequencer.
package bus_seq_pkg;

  localparam int SLOT_W  = 2;
  localparam int N_SLOTS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    GRANT = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic              found;
    logic [SLOT_W-1:0] slot;
  } rr_result_t;

  // Scan cnt+1, cnt+2, cnt+3 and finally cnt itself; the first requester wins.
  // The wrap to cnt comes for free because the slot arithmetic is mod N_SLOTS.
  function automatic rr_result_t rr_next(input logic [SLOT_W-1:0]  cnt,
                                         input logic [N_SLOTS-1:0] req);
    rr_result_t        res;
    logic [SLOT_W-1:0] idx;
    res.found = 1'b0;
    res.slot  = cnt;
    for (int k = 1; k <= N_SLOTS; k++) begin
      idx = cnt + SLOT_W'(k);
      if (!res.found && req[idx]) begin
        res.found = 1'b1;
        res.slot  = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/slot_prescaler.sv
// Dwell prescaler: counts while enabled, clear has priority, flags TICK_DIV-1.
module slot_prescaler #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins over increment, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/bus_slot_sequencer.sv
// Round-robin slot sequencer for a tri-state shared bus. Every slot change
// passes through a one-cycle GAP with en low, so drivers never overlap.
module bus_slot_sequencer
  import bus_seq_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step,
  input  logic [3:0] req,
  output logic [1:0] cnt,
  output logic       en,
  output logic       adv
);

  seq_state_t        state_q;
  seq_state_t        state_d;
  logic [SLOT_W-1:0] cnt_q;
  logic [SLOT_W-1:0] cnt_d;
  logic              adv_q;
  logic              adv_d;
  logic              step_q;
  logic              step_prev_q;
  logic              in_grant;
  logic              step_edge;
  logic              adv_evt;
  logic              tc;
  logic              ps_clr;
  logic              ps_inc;
  rr_result_t        rr;

  assign in_grant = (state_q == GRANT);
  assign rr       = rr_next(cnt_q, req);

  // A step edge is only meaningful in GRANT; elsewhere it is simply lost.
  assign step_edge = in_grant & step_q & ~step_prev_q;

  // Any advance source collapses into one event.
  assign adv_evt = in_grant & ((run & tc) | step_edge | ~req[cnt_q]);

  // Prescaler restarts on GRANT entry (it is held clear outside GRANT),
  // on every advance, and whenever run is low, so each dwell is a full period.
  assign ps_inc = in_grant & run;
  assign ps_clr = ~in_grant | ~run | adv_evt;

  slot_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (ps_clr),
    .inc_i (ps_inc),
    .tc_o  (tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the slot/adv values loaded on entry to GAP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adv_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rr.found) begin
          state_d = GAP;
          cnt_d   = rr.slot;
          adv_d   = 1'b1;
        end
      end
      GAP: begin
        state_d = GRANT;
      end
      GRANT: begin
        if (adv_evt) begin
          if (!rr.found) begin
            state_d = IDLE;
          end else if (rr.slot != cnt_q) begin
            state_d = GAP;
            cnt_d   = rr.slot;
            adv_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Slot index, advance pulse and the two-stage step sampler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 2'b11;
      adv_q       <= 1'b0;
      step_q      <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      adv_q       <= adv_d;
      step_q      <= step;
      step_prev_q <= step_q;
    end
  end

  // Outputs decoded from registers only, so they are glitch-free.
  always_comb begin
    en  = (state_q == GRANT);
    cnt = cnt_q;
    adv = adv_q;
  end

endmodule

// File: tb/tb_bus_slot_sequencer.sv
// Directed bench for bus_slot_sequencer with TICK_DIV=4: a per-cycle
// behavioural model plus hand-computed expectations for each scenario.
module tb_bus_slot_sequencer;

  localparam int TD = 4;
  localparam int M_IDLE  = 0;
  localparam int M_GAP   = 1;
  localparam int M_GRANT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [1:0] cnt;
  logic       en;
  logic       adv;

  int tests = 0;
  int fails = 0;

  // Model state: mode, current slot, cycles spent in the current dwell,
  // last two sampled step values, and the expected adv pulse.
  int m_mode  = M_IDLE;
  int m_slot  = 3;
  int m_dwell = 0;
  bit m_adv   = 0;
  bit m_s1    = 0;
  bit m_s2    = 0;

  logic [1:0] prev_cnt = 2'b11;
  int         run_len  = 0;
  int         gap_log[$];
  int         en_runs[$];

  bus_slot_sequencer #(.TICK_DIV(TD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .step  (step),
    .req   (req),
    .cnt   (cnt),
    .en    (en),
    .adv   (adv)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int from, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(from + k) % 4]) return (from + k) % 4;
    end
    return from;
  endfunction

  // Model update on each edge, then compare the DUT 1 time unit later.
  always begin
    bit edge_seen;
    bit advance;
    int nxt;
    @(posedge clk);
    m_adv = 0;
    if (!rst_n) begin
      m_mode = M_IDLE; m_slot = 3; m_dwell = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      edge_seen = m_s1 && !m_s2;
      m_s2 = m_s1;
      m_s1 = step;
      if (m_mode == M_IDLE) begin
        if (req != 4'b0000) begin
          m_slot = pick(m_slot, req); m_mode = M_GAP; m_adv = 1;
        end
      end else if (m_mode == M_GAP) begin
        m_mode = M_GRANT; m_dwell = 0;
      end else begin
        advance = (run && m_dwell == TD - 1) || edge_seen || !req[m_slot];
        if (advance) begin
          m_dwell = 0;
          if (req == 4'b0000) begin
            m_mode = M_IDLE;
          end else begin
            nxt = pick(m_slot, req);
            if (nxt != m_slot) begin
              m_slot = nxt; m_mode = M_GAP; m_adv = 1;
            end
          end
        end else begin
          m_dwell = run ? m_dwell + 1 : 0;
        end
      end
    end
    #1;
    check("cnt", cnt, m_slot);
    check("en", en, (m_mode == M_GRANT) ? 1 : 0);
    check("adv", adv, m_adv ? 1 : 0);
    check("break_before_make", (cnt != prev_cnt) ? en : 1'b0, 0);
    prev_cnt = cnt;
    if (adv === 1'b1) gap_log.push_back(int'(cnt));
    if (en === 1'b1) begin
      run_len++;
    end else if (run_len > 0) begin
      en_runs.push_back(run_len);
      run_len = 0;
    end
  end

  task automatic do_reset(input logic [3:0] r, input logic rn);
    rst_n = 1'b0;
    req   = r;
    run   = rn;
    step  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gap_log.delete();
    en_runs.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int exp1[5];
    int exp2[3];
    exp1 = '{0, 1, 2, 3, 0};
    exp2 = '{0, 2, 0};

    @(negedge clk);
    check("reset_en", en, 0);
    check("reset_cnt", cnt, 3);
    check("reset_adv", adv, 0);

    // Full rotation in run mode.
    do_reset(4'b1111, 1'b1);
    cycles(24);
    check("rot_gap_count", gap_log.size(), 5);
    for (int i = 0; i < 5; i++)
      check("rot_cnt_seq", (i < gap_log.size()) ? gap_log[i] : -1, exp1[i]);
    check("rot_en_runs", en_runs.size(), 4);
    for (int i = 0; i < 4; i++)
      check("rot_dwell_len", (i < en_runs.size()) ? en_runs[i] : -1, TD);

    // Sparse requests: only slots 0 and 2.
    do_reset(4'b0101, 1'b1);
    cycles(24);
    check("sparse_gap_count", gap_log.size(), 5);
    for (int i = 0; i < 3; i++)
      check("sparse_cnt_seq", (i < gap_log.size()) ? gap_log[i] : -1, exp2[i]);
    foreach (gap_log[i]) check("sparse_no_odd_slot", gap_log[i] % 2, 0);

    // Single-step with run low.
    do_reset(4'b1111, 1'b0);
    cycles(4);
    check("step_hold_cnt", cnt, 0);
    check("step_hold_en", en, 1);
    gap_log.delete();
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      check("step_no_gap_yet", adv, 0);
      @(negedge clk);
      check("step_gap_adv", adv, 1);
      check("step_gap_en", en, 0);
      check("step_gap_cnt", cnt, p + 1);
      cycles(5);
    end
    check("step_gap_total", gap_log.size(), 3);

    // Requests vanish in GRANT, then a new one arrives.
    do_reset(4'b0010, 1'b0);
    cycles(4);
    check("drop_pre_cnt", cnt, 1);
    req = 4'b0000;
    @(negedge clk);
    check("drop_idle_en", en, 0);
    check("drop_idle_cnt", cnt, 1);
    check("drop_idle_adv", adv, 0);
    @(negedge clk);
    check("drop_idle_hold", en, 0);
    req = 4'b0001;
    @(negedge clk);
    check("rearm_gap_adv", adv, 1);
    check("rearm_gap_cnt", cnt, 0);
    check("rearm_gap_en", en, 0);
    @(negedge clk);
    check("rearm_grant_en", en, 1);
    check("rearm_grant_cnt", cnt, 0);

    // Lone requester keeps the bus without gaps.
    do_reset(4'b1000, 1'b1);
    cycles(3);
    gap_log.delete();
    en_runs.delete();
    cycles(20);
    check("solo_no_gaps", gap_log.size(), 0);
    check("solo_no_en_drop", en_runs.size(), 0);
    check("solo_cnt", cnt, 3);
    check("solo_en", en, 1);

    // Asynchronous reset while granting.
    rst_n = 1'b0;
    #1;
    check("async_rst_en", en, 0);
    check("async_rst_cnt", cnt, 3);
    cycles(2);
    rst_n = 1'b1;
    cycles(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
